// File: rtl/branch_predict_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// branch_predict_unit : execute-stage branch resolve + BHT/BTB fetch predictor
// Revision 1.0
// ------------------------------------------------------------------
module branch_predict_unit #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             branch,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken_in,
  input  logic [XLEN-1:0]  pred_target_in,
  output logic             take_branch,
  output logic [XLEN-1:0]  branch_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [1:0] c_ctr_weak_nt = 2'b01;
  localparam logic [1:0] c_ctr_max     = 2'b11;
  localparam logic [1:0] c_ctr_min     = 2'b00;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             resolve;
  logic             cond_taken;
  logic             funct_illegal;
  logic             table_we;
  logic             lookup_hit;
  logic             unused_pc_lsbs;

  logic [1:0]       ctr_rd        [ENTRIES];
  logic             btb_valid_rd  [ENTRIES];
  logic [TAG_W-1:0] btb_tag_rd    [ENTRIES];
  logic [XLEN-1:0]  btb_target_rd [ENTRIES];

  logic [CNT_W-1:0] branch_count_d, branch_count_q;
  logic [CNT_W-1:0] mispredict_count_d, mispredict_count_q;

  assign f_idx  = fetch_pc[IDX_W+1:2];
  assign f_tag  = fetch_pc[XLEN-1:IDX_W+2];
  assign ex_idx = pc[IDX_W+1:2];
  assign ex_tag = pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{fetch_pc[1:0], pc[1:0]};

  // Fetch lookup reads registered state only, so an update lands the cycle after.
  assign lookup_hit  = btb_valid_rd[f_idx] && (btb_tag_rd[f_idx] == f_tag);
  assign pred_taken  = lookup_hit && ctr_rd[f_idx][1];
  assign pred_target = lookup_hit ? btb_target_rd[f_idx] : fetch_pc + XLEN'(4);

  always_comb begin
    cond_taken    = 1'b0;
    funct_illegal = 1'b0;
    case (funct3)
      3'b000:  cond_taken = (rs1_data == rs2_data);
      3'b001:  cond_taken = (rs1_data != rs2_data);
      3'b100:  cond_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond_taken = (rs1_data <  rs2_data);
      3'b111:  cond_taken = (rs1_data >= rs2_data);
      default: funct_illegal = 1'b1;
    endcase
  end

  assign resolve        = ex_valid && branch;
  assign take_branch    = resolve && cond_taken;
  assign illegal_branch = resolve && funct_illegal;
  assign branch_target  = pc + imm;
  assign redirect_pc    = take_branch ? branch_target : pc + XLEN'(4);
  assign mispredict     = resolve && !funct_illegal &&
                          ((pred_taken_in != take_branch) ||
                           (take_branch && (pred_target_in != branch_target)));
  assign table_we       = resolve && !funct_illegal;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic             wr_en;
    logic [1:0]       ctr_d, ctr_q;
    logic             valid_d, valid_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic [XLEN-1:0]  target_d, target_q;

    always_comb begin
      wr_en    = table_we && (ex_idx == IDX_W'(i));
      ctr_d    = ctr_q;
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (wr_en) begin
        if (take_branch) begin
          if (ctr_q != c_ctr_max) ctr_d = ctr_q + 2'b01;
          valid_d  = 1'b1;
          tag_d    = ex_tag;
          target_d = branch_target;
        end else if (ctr_q != c_ctr_min) begin
          ctr_d = ctr_q - 2'b01;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctr_q    <= c_ctr_weak_nt;
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
      end else begin
        ctr_q    <= ctr_d;
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
      end
    end

    assign ctr_rd[i]        = ctr_q;
    assign btb_valid_rd[i]  = valid_q;
    assign btb_tag_rd[i]    = tag_q;
    assign btb_target_rd[i] = target_q;
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && (branch_count_q != '1))
      branch_count_d = branch_count_q + CNT_W'(1);
    if (mispredict && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_branch_predict_unit : directed + random checks against a table model
// Revision 1.0
// ------------------------------------------------------------------
module tb_branch_predict_unit;

  localparam int XLEN    = 64;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] fetch_pc, rs1_data, rs2_data, pc, imm, pred_target_in;
  logic        ex_valid, branch, pred_taken_in;
  logic [2:0]  funct3;

  logic        pred_taken, take_branch, mispredict, illegal_branch;
  logic [63:0] pred_target, branch_target, redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  logic        s_pred_taken, s_take_branch, s_mispredict, s_illegal_branch;
  logic [63:0] s_pred_target, s_branch_target, s_redirect_pc;
  logic [3:0]  s_branch_count, s_mispredict_count;

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .branch(branch), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
    .pred_taken_in(pred_taken_in), .pred_target_in(pred_target_in),
    .take_branch(take_branch), .branch_target(branch_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .illegal_branch(illegal_branch),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .ex_valid(ex_valid), .branch(branch), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
    .pred_taken_in(pred_taken_in), .pred_target_in(pred_target_in),
    .take_branch(s_take_branch), .branch_target(s_branch_target),
    .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
    .illegal_branch(s_illegal_branch),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  bit          chk_on = 1'b0;

  int          m_ctr   [ENTRIES];
  bit          m_valid [ENTRIES];
  logic [63:0] m_tag   [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  logic [63:0] m_bc, m_mc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_ctr[i] = 1; m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_bc = '0; m_mc = '0;
  endtask

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic void look(input logic [63:0] fpc, output bit pt, output logic [63:0] tgt);
    int  i;
    bit  hit;
    i   = idx_of(fpc);
    hit = m_valid[i] && (m_tag[i] == (fpc >> (IDX_W + 2)));
    pt  = hit && (m_ctr[i] >= 2);
    tgt = hit ? m_tgt[i] : fpc + 64'd4;
  endfunction

  function automatic void res_eval(output bit rs, output bit tk, output bit ill, output bit mis);
    bit c;
    bit f_ill;
    f_ill = 1'b0;
    rs    = ex_valid && branch;
    case (funct3)
      3'b000:  c = (rs1_data == rs2_data);
      3'b001:  c = (rs1_data != rs2_data);
      3'b100:  c = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  c = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  c = (rs1_data <  rs2_data);
      3'b111:  c = (rs1_data >= rs2_data);
      default: begin c = 1'b0; f_ill = 1'b1; end
    endcase
    tk  = rs && c;
    ill = rs && f_ill;
    mis = rs && !ill && ((pred_taken_in != tk) || (tk && (pred_target_in != pc + imm)));
  endfunction

  task automatic model_tick();
    bit rs, tk, ill, mis;
    int i;
    if (!rst_n) begin
      model_reset();
      return;
    end
    res_eval(rs, tk, ill, mis);
    if (rs) m_bc++;
    if (mis) m_mc++;
    if (rs && !ill) begin
      i = idx_of(pc);
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_valid[i] = 1'b1;
        m_tag[i]   = pc >> (IDX_W + 2);
        m_tgt[i]   = pc + imm;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic drive_br(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] p, input logic [63:0] im,
                          input logic pti, input logic [63:0] ptg);
    ex_valid = 1'b1; branch = 1'b1; funct3 = f;
    rs1_data = a; rs2_data = b; pc = p; imm = im;
    pred_taken_in = pti; pred_target_in = ptg;
  endtask

  task automatic idle();
    ex_valid = 1'b0; branch = 1'b0;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return '1;
      3:       return 64'd5;
      4:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Every meaningful cycle: all outputs against the table model.
  always @(negedge clk) begin
    bit          rs, tk, ill, mis, pt;
    logic [63:0] pg, tgt;
    if (chk_on) begin
      look(fetch_pc, pt, pg);
      res_eval(rs, tk, ill, mis);
      tgt = pc + imm;
      chk("pred_taken", pred_taken, pt);
      chk("pred_target", pred_target, pg);
      chk("take_branch", take_branch, tk);
      chk("branch_target", branch_target, tgt);
      chk("redirect_pc", redirect_pc, tk ? tgt : pc + 64'd4);
      chk("mispredict", mispredict, mis);
      chk("illegal_branch", illegal_branch, ill);
      chk("branch_count", branch_count, m_bc & 64'hFFFF_FFFF);
      chk("mispredict_count", mispredict_count, m_mc & 64'hFFFF_FFFF);
      chk("sat_branch_count", s_branch_count, (m_bc > 15) ? 64'd15 : m_bc);
      chk("sat_mispredict_count", s_mispredict_count, (m_mc > 15) ? 64'd15 : m_mc);
    end
  end

  initial begin
    logic [63:0] bc_before;
    bit          pt;
    logic [63:0] pg;
    int          k;

    fetch_pc = 64'h1000; ex_valid = 1'b0; branch = 1'b0; funct3 = 3'b000;
    rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;
    pred_taken_in = 1'b0; pred_target_in = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pred_taken", pred_taken, 64'd0);
    chk("rst_pred_target", pred_target, 64'h1004);
    chk("rst_branch_count", branch_count, 64'd0);
    chk("rst_mispredict_count", mispredict_count, 64'd0);
    chk_on = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // BEQ taken from an untrained predictor
    drive_br(3'b000, 64'd5, 64'd5, 64'h1000, 64'h40, 1'b0, 64'd0);
    #1;
    chk("beq_take", take_branch, 64'd1);
    chk("beq_target", branch_target, 64'h1040);
    chk("beq_mispredict", mispredict, 64'd1);
    chk("beq_redirect", redirect_pc, 64'h1040);
    step();
    idle(); fetch_pc = 64'h1000;
    #1;
    chk("beq_trained_taken", pred_taken, 64'd1);
    chk("beq_trained_target", pred_target, 64'h1040);
    chk("beq_branch_count", branch_count, 64'd1);
    chk("beq_mis_count", mispredict_count, 64'd1);
    step();

    // Signed vs unsigned comparisons on -1 / 1
    drive_br(3'b100, '1, 64'd1, 64'h2000, 64'd8, 1'b1, 64'h2008);
    #1; chk("blt_take", take_branch, 64'd1);
    idle(); step();
    drive_br(3'b110, '1, 64'd1, 64'h2000, 64'd8, 1'b0, 64'd0);
    #1; chk("bltu_take", take_branch, 64'd0); chk("bltu_redirect", redirect_pc, 64'h2004);
    idle(); step();
    drive_br(3'b101, '1, 64'd1, 64'h2000, 64'd8, 1'b0, 64'd0);
    #1; chk("bge_take", take_branch, 64'd0);
    idle(); step();
    drive_br(3'b111, '1, 64'd1, 64'h2000, 64'd8, 1'b0, 64'd0);
    #1; chk("bgeu_take", take_branch, 64'd1);
    idle(); step();

    // Counter saturation at one index (pc 0x3008 -> idx 2)
    drive_br(3'b001, 64'd7, 64'd7, 64'h3008, 64'h20, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) step();
    drive_br(3'b000, 64'd7, 64'd7, 64'h3008, 64'h20, 1'b0, 64'd0);
    step();
    idle(); fetch_pc = 64'h3008;
    #1;
    chk("sat_low_taken", pred_taken, 64'd0);
    chk("sat_low_target", pred_target, 64'h3028);
    drive_br(3'b000, 64'd7, 64'd7, 64'h3008, 64'h20, 1'b1, 64'h3028);
    for (int i = 0; i < 4; i++) step();
    drive_br(3'b001, 64'd7, 64'd7, 64'h3008, 64'h20, 1'b1, 64'h3028);
    step();
    idle();
    #1; chk("sat_high_dec_taken", pred_taken, 64'd1);
    drive_br(3'b001, 64'd7, 64'd7, 64'h3008, 64'h20, 1'b1, 64'h3028);
    step();
    idle();
    #1; chk("sat_high_dec2_taken", pred_taken, 64'd0);

    // Alias: 0x1000 + 4*ENTRIES shares index 0
    drive_br(3'b000, 64'd1, 64'd1, 64'h1040, 64'h100, 1'b0, 64'd0);
    step();
    idle(); fetch_pc = 64'h1000;
    #1; chk("alias_old_taken", pred_taken, 64'd0); chk("alias_old_target", pred_target, 64'h1004);
    fetch_pc = 64'h1040;
    #1; chk("alias_new_taken", pred_taken, 64'd1); chk("alias_new_target", pred_target, 64'h1140);
    step();

    // Illegal funct3 only bumps branch_count
    bc_before = m_bc;
    drive_br(3'b010, 64'd9, 64'd9, 64'h1040, 64'h40, 1'b1, 64'h1080);
    #1;
    chk("illegal_flag", illegal_branch, 64'd1);
    chk("illegal_take", take_branch, 64'd0);
    chk("illegal_mispredict", mispredict, 64'd0);
    step();
    idle();
    #1;
    chk("illegal_branch_count", branch_count, bc_before + 64'd1);
    chk("illegal_table_taken", pred_taken, 64'd1);
    chk("illegal_table_target", pred_target, 64'h1140);

    // Twenty forced mispredicts: the 4-bit counters must stick at 15
    drive_br(3'b000, 64'd3, 64'd3, 64'h5000, 64'h10, 1'b0, 64'd0);
    for (int i = 0; i < 20; i++) step();
    idle();
    #1;
    chk("sat4_mispredict_count", s_mispredict_count, 64'hF);
    chk("sat4_branch_count", s_branch_count, 64'hF);

    // Random phase with occasional mid-cycle asynchronous reset
    for (int n = 0; n < 4000; n++) begin
      ex_valid = ($urandom_range(0, 3) != 0);
      branch   = ($urandom_range(0, 4) != 0);
      funct3   = 3'($urandom_range(0, 7));
      rs1_data = pick();
      rs2_data = ($urandom_range(0, 2) == 0) ? rs1_data : pick();
      pc       = 64'h1000 + 64'(4 * $urandom_range(0, 39));
      if ($urandom_range(0, 9) == 0) pc[63:32] = $urandom();
      k        = int'($urandom_range(0, 15)) * 4 - 32;
      imm      = {{32{k[31]}}, k};
      look(pc, pt, pg);
      if ($urandom_range(0, 3) != 0) begin
        pred_taken_in = pt; pred_target_in = pg;
      end else begin
        pred_taken_in  = 1'($urandom_range(0, 1));
        pred_target_in = pc + 64'(4 * $urandom_range(0, 15));
      end
      fetch_pc = 64'h1000 + 64'(4 * $urandom_range(0, 39));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
